// File: rtl/inst_fetch_if.sv
// Fetch-request / response channel plus the word-wide instruction RAM port
// seen by the memory-side fetch responder.
interface inst_fetch_if;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic        inst_ok;
    logic        inst_ok_1;
    logic        inst_ok_2;
    logic [31:0] inst_data_1;
    logic [31:0] inst_data_2;
    logic        ram_req;
    logic [31:0] ram_addr;
    logic        ram_gnt;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;

    // Responder side: serves fetches and issues RAM reads.
    modport slave (
        input  inst_en, inst_addr, ram_gnt, ram_rvalid, ram_rdata,
        output inst_ok, inst_ok_1, inst_ok_2, inst_data_1, inst_data_2,
               ram_req, ram_addr
    );

    // Environment side: pipeline front end plus the RAM.
    modport master (
        output inst_en, inst_addr, ram_gnt, ram_rvalid, ram_rdata,
        input  inst_ok, inst_ok_1, inst_ok_2, inst_data_1, inst_data_2,
               ram_req, ram_addr
    );
endinterface

// File: rtl/inst_fetch_responder.sv
// Memory-side end of the dual-issue instruction channel: fetches one or two
// consecutive words from a req/gnt RAM port and returns them in one pulse.
module inst_fetch_responder #(
    parameter int unsigned BLOCK_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    inst_fetch_if.slave bus
);
    localparam int unsigned BLK_LSB = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_REQ2,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        two_words_q, two_words_d;
    logic [1:0]  gnt_cnt_q, gnt_cnt_d;
    logic [1:0]  rsp_cnt_q, rsp_cnt_d;
    logic        inst_ok_q, inst_ok_d;
    logic        inst_ok_1_q, inst_ok_1_d;
    logic        inst_ok_2_q, inst_ok_2_d;
    logic [31:0] inst_data_1_q, inst_data_1_d;
    logic [31:0] inst_data_2_q, inst_data_2_d;
    logic        ram_req_q, ram_req_d;
    logic [31:0] ram_addr_q, ram_addr_d;

    logic        grant;
    logic        rsp_window;
    logic [1:0]  gnt_total;
    logic        rsp_take;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        two_words_d   = two_words_q;
        gnt_cnt_d     = gnt_cnt_q;
        rsp_cnt_d     = rsp_cnt_q;
        inst_ok_d     = 1'b0;
        inst_ok_1_d   = 1'b0;
        inst_ok_2_d   = 1'b0;
        inst_data_1_d = inst_data_1_q;
        inst_data_2_d = inst_data_2_q;
        ram_req_d     = ram_req_q;
        ram_addr_d    = ram_addr_q;

        grant      = ram_req_q && bus.ram_gnt;
        rsp_window = (state_q == S_REQ2) || (state_q == S_WAIT) ||
                     ((state_q == S_REQ1) && grant);
        // Responses are capped by grants issued so far, including this cycle's.
        gnt_total  = gnt_cnt_q + {1'b0, grant};
        rsp_take   = bus.ram_rvalid && rsp_window && (rsp_cnt_q < gnt_total);

        if (rsp_take) begin
            rsp_cnt_d = rsp_cnt_q + 2'd1;
            if (rsp_cnt_q == 2'd0) begin
                inst_data_1_d = bus.ram_rdata;
            end else begin
                inst_data_2_d = bus.ram_rdata;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.inst_en) begin
                    addr_d = bus.inst_addr;
                    if (bus.inst_addr[1:0] != 2'b00) begin
                        state_d   = S_RESP;
                        inst_ok_d = 1'b1;
                    end else begin
                        inst_data_1_d = '0;
                        inst_data_2_d = '0;
                        gnt_cnt_d     = '0;
                        rsp_cnt_d     = '0;
                        // Slot 2 would cross the fetch block when the word index is last.
                        two_words_d   = ~&bus.inst_addr[BLK_LSB-1:2];
                        ram_req_d     = 1'b1;
                        ram_addr_d    = bus.inst_addr;
                        state_d       = S_REQ1;
                    end
                end
            end
            S_REQ1: begin
                if (grant) begin
                    gnt_cnt_d = gnt_cnt_q + 2'd1;
                    if (two_words_q) begin
                        ram_addr_d = addr_q + 32'd4;
                        state_d    = S_REQ2;
                    end else begin
                        ram_req_d = 1'b0;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_REQ2: begin
                if (grant) begin
                    gnt_cnt_d = gnt_cnt_q + 2'd1;
                    ram_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_cnt_q == gnt_cnt_q) begin
                    inst_ok_d   = 1'b1;
                    inst_ok_1_d = 1'b1;
                    inst_ok_2_d = two_words_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            two_words_q   <= 1'b0;
            gnt_cnt_q     <= '0;
            rsp_cnt_q     <= '0;
            inst_ok_q     <= 1'b0;
            inst_ok_1_q   <= 1'b0;
            inst_ok_2_q   <= 1'b0;
            inst_data_1_q <= '0;
            inst_data_2_q <= '0;
            ram_req_q     <= 1'b0;
            ram_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            two_words_q   <= two_words_d;
            gnt_cnt_q     <= gnt_cnt_d;
            rsp_cnt_q     <= rsp_cnt_d;
            inst_ok_q     <= inst_ok_d;
            inst_ok_1_q   <= inst_ok_1_d;
            inst_ok_2_q   <= inst_ok_2_d;
            inst_data_1_q <= inst_data_1_d;
            inst_data_2_q <= inst_data_2_d;
            ram_req_q     <= ram_req_d;
            ram_addr_q    <= ram_addr_d;
        end
    end

    assign bus.inst_ok     = inst_ok_q;
    assign bus.inst_ok_1   = inst_ok_1_q;
    assign bus.inst_ok_2   = inst_ok_2_q;
    assign bus.inst_data_1 = inst_data_1_q;
    assign bus.inst_data_2 = inst_data_2_q;
    assign bus.ram_req     = ram_req_q;
    assign bus.ram_addr    = ram_addr_q;
endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench for inst_fetch_responder: a RAM model with configurable
// grant stall and read latency, and an expected-response queue per fetch.
module tb_inst_fetch_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_fetch_if bus ();

    inst_fetch_responder #(.BLOCK_BYTES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok1;
        logic        ok2;
        logic [31:0] d1;
        logic [31:0] d2;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } rsp_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned gnt_stall = 0;
    int unsigned rv_lat    = 1;
    int unsigned stall_cnt = 0;
    int unsigned drain_timeouts = 0;
    bit          model_idle = 1'b1;
    bit          prev_ok    = 1'b0;
    bit          rst_prev   = 1'b0;
    bit          tb_done    = 1'b0;
    bit          final_done = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    rsp_t        pend_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        if (a == 32'hBFC0_0004) return 32'h2409_0002;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
    endfunction

    // RAM model, response scoreboard and capture model, all on the falling edge.
    always @(negedge clk) begin : mon
        bit          go_idle;
        exp_t        e;
        rsp_t        r;
        logic [31:0] a;
        cyc++;
        go_idle = 1'b0;
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
            pend_q.delete();
            model_idle     = 1'b1;
            prev_ok        = 1'b0;
            rst_prev       = 1'b1;
            stall_cnt      = 0;
            bus.ram_gnt    = 1'b0;
            bus.ram_rvalid = 1'b0;
            bus.ram_rdata  = '0;
        end else begin
            if (rst_prev) begin
                check("rst_inst_ok",   {31'd0, bus.inst_ok}, 32'd0);
                check("rst_ok_flags",  {30'd0, bus.inst_ok_1, bus.inst_ok_2}, 32'd0);
                check("rst_data_1",    bus.inst_data_1, 32'd0);
                check("rst_data_2",    bus.inst_data_2, 32'd0);
                check("rst_ram_req",   {31'd0, bus.ram_req}, 32'd0);
                check("rst_ram_addr",  bus.ram_addr, 32'd0);
                rst_prev = 1'b0;
            end

            if (bus.inst_ok) begin
                check("ok_gap", {31'd0, prev_ok}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("ok_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ok_1", {31'd0, bus.inst_ok_1}, {31'd0, e.ok1});
                    check("ok_2", {31'd0, bus.inst_ok_2}, {31'd0, e.ok2});
                    if (e.ok1) check("data_1", bus.inst_data_1, e.d1);
                    if (e.ok2) check("data_2", bus.inst_data_2, e.d2);
                    if (e.due != 0) check("ok_latency", cyc, e.due);
                end
                check("grants_missing", addr_q.size(), 32'd0);
                go_idle = 1'b1;
            end else begin
                check("ok_flags_idle", {30'd0, bus.inst_ok_1, bus.inst_ok_2}, 32'd0);
            end
            prev_ok = bus.inst_ok;

            bus.ram_gnt = 1'b0;
            if (bus.ram_req) begin
                if (addr_q.size() == 0) begin
                    check("ram_req_unexpected", 32'd1, 32'd0);
                    bus.ram_gnt = 1'b1;
                    pend_q.push_back('{mem_word(bus.ram_addr), cyc + rv_lat});
                end else begin
                    check("ram_addr", bus.ram_addr, addr_q[0]);
                    if (stall_cnt < gnt_stall) begin
                        stall_cnt++;
                    end else begin
                        bus.ram_gnt = 1'b1;
                        stall_cnt   = 0;
                        void'(addr_q.pop_front());
                        pend_q.push_back('{mem_word(bus.ram_addr), cyc + rv_lat});
                    end
                end
            end

            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                r = pend_q.pop_front();
                bus.ram_rvalid = 1'b1;
                bus.ram_rdata  = r.data;
            end else begin
                bus.ram_rvalid = 1'b0;
                bus.ram_rdata  = $urandom;
            end

            // The upcoming rising edge samples inst_en/inst_addr in IDLE.
            if (model_idle && bus.inst_en) begin
                a = bus.inst_addr;
                if (a[1:0] != 2'b00) begin
                    e = '{1'b0, 1'b0, 32'd0, 32'd0, cyc + 1};
                end else begin
                    e.ok1 = 1'b1;
                    e.ok2 = (a[4:2] != 3'b111);
                    e.d1  = mem_word(a);
                    e.d2  = mem_word(a + 32'd4);
                    e.due = (e.ok2 && gnt_stall == 0 && rv_lat == 1) ? cyc + 5 : 0;
                    addr_q.push_back(a);
                    if (e.ok2) addr_q.push_back(a + 32'd4);
                end
                exp_q.push_back(e);
                model_idle = 1'b0;
            end
            if (go_idle) model_idle = 1'b1;

            if (tb_done && !final_done) begin
                check("drain_timeouts", drain_timeouts, 32'd0);
                check("exp_queue_empty", exp_q.size(), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && model_idle) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            $display("FAIL drain: scoreboard not empty after 400 cycles, %0d pending", exp_q.size());
            drain_timeouts++;
        end
    endtask

    task automatic fetch(input logic [31:0] addr);
        @(posedge clk);
        #1;
        bus.inst_en   = 1'b1;
        bus.inst_addr = addr;
        @(posedge clk);
        #1;
        bus.inst_en   = 1'b0;
        bus.inst_addr = $urandom;
        wait_drain();
    endtask

    task automatic burst(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.inst_en   = 1'b1;
            bus.inst_addr = 32'h8000_0000 + ($urandom_range(0, 63) << 1);
        end
        @(posedge clk);
        #1;
        bus.inst_en = 1'b0;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.inst_en   = 1'b0;
        bus.inst_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        fetch(32'hBFC0_0000);
        fetch(32'hBFC0_001C);
        fetch(32'hBFC0_0002);
        fetch(32'hFFFF_FFF8);
        fetch(32'hFFFF_FFFC);

        gnt_stall = 3;
        rv_lat    = 4;
        fetch(32'hBFC0_0010);
        fetch(32'hBFC0_0018);
        gnt_stall = 0;
        rv_lat    = 1;

        // Reset while waiting with one of two responses returned.
        rv_lat = 2;
        @(posedge clk);
        #1;
        bus.inst_en   = 1'b1;
        bus.inst_addr = 32'h0000_0200;
        @(posedge clk);
        #1;
        bus.inst_en   = 1'b0;
        bus.inst_addr = 32'h0000_0300;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rv_lat = 1;
        fetch(32'h0000_0100);

        burst(40);
        gnt_stall = 1;
        rv_lat    = 2;
        burst(40);
        gnt_stall = 0;
        rv_lat    = 1;

        tb_done = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
